// File: rtl/board_pkg.sv
// board_pkg: shared constants, snapshot record and helpers for the board display scanner
package board_pkg;
    localparam int N_CELLS = 10;
    localparam int N_COLS  = 5;
    localparam int CELL_W  = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef struct packed {
        logic [N_CELLS*CELL_W-1:0] status;
        logic [2:0]                num;
        logic [3:0]                cursor_idx;
        logic                      sel_valid;
        logic [3:0]                sel_idx;
        logic                      phase;
    } snap_t;

    function automatic logic [2:0] col_of(input logic [3:0] idx);
        logic [3:0] m;
        m = idx % 4'd5;
        return m[2:0];
    endfunction
endpackage

// File: rtl/board_display_scan_if.sv
// board_display_scan_if: board status inputs and multiplexed display outputs
interface board_display_scan_if;
    import board_pkg::*;
    logic [N_CELLS*CELL_W-1:0] status;
    logic [2:0]                num;
    logic [3:0]                cursor_idx;
    logic                      sel_valid;
    logic [3:0]                sel_idx;
    logic [N_CELLS-1:0]        seg_an;
    logic [7:0]                seg_out;
    logic                      frame_tick;

    modport master (output status, num, cursor_idx, sel_valid, sel_idx,
                    input  seg_an, seg_out, frame_tick);
    modport slave  (input  status, num, cursor_idx, sel_valid, sel_idx,
                    output seg_an, seg_out, frame_tick);
endinterface

// File: rtl/seg7_digit_dec.sv
// seg7_digit_dec: 4-bit value plus decimal-point enable to active-low segment byte
module seg7_digit_dec
    import board_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_dp_en,
    output logic [7:0] o_seg
);
    // Digits 0..9 come from the table; anything larger is shown as a dash
    always_comb begin
        o_seg = {~i_dp_en, (i_val < 4'd10) ? SEG_TABLE[i_val] : SEG_DASH};
    end
endmodule

// File: rtl/board_display_scan.sv
// board_display_scan: scans the 10-cell board onto a multiplexed 7-segment display
module board_display_scan
    import board_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    board_display_scan_if.slave  bus
);
    localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0]      r_pre;
    logic [BW-1:0]      r_blink;
    logic [3:0]         r_ptr;
    logic               r_phase;
    logic               r_first;
    logic               r_tick;
    logic [N_CELLS-1:0] r_an;
    logic [7:0]         r_out;
    snap_t              r_snap;

    snap_t      w_live;
    snap_t      w_view;
    logic       w_pre_end;
    logic       w_blink_end;
    logic       w_snap;
    logic       w_blank;
    logic       w_dp;
    logic [2:0] w_num_eff;
    logic [3:0] w_val;
    logic [7:0] w_seg;

    // Terminal counts, snapshot strobe and the view of the current digit
    always_comb begin
        w_pre_end   = r_pre == SW'(SCAN_DIV - 1);
        w_blink_end = r_blink == BW'(BLINK_DIV - 1);
        w_snap      = r_first || (w_pre_end && r_ptr == 4'd9);
        w_live      = '{status: bus.status, num: bus.num, cursor_idx: bus.cursor_idx,
                        sel_valid: bus.sel_valid, sel_idx: bus.sel_idx, phase: r_phase};
        w_view      = r_first ? w_live : r_snap;
        w_num_eff   = (w_view.num == 3'd0) ? 3'd1 : (w_view.num > 3'd5) ? 3'd5 : w_view.num;
        w_val       = w_view.status[{r_ptr, 2'b00} +: CELL_W];
        w_blank     = (col_of(r_ptr) >= w_num_eff) || (r_ptr == w_view.cursor_idx && w_view.phase);
        w_dp        = w_view.sel_valid && r_ptr == w_view.sel_idx && !w_blank;
    end

    seg7_digit_dec u_dec (
        .i_val   (w_val),
        .i_dp_en (w_dp),
        .o_seg   (w_seg)
    );

    // Digit prescaler and pointer walking 0..9
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_ptr <= '0;
        end else begin
            r_pre <= w_pre_end ? '0 : r_pre + 1'b1;
            if (w_pre_end) r_ptr <= (r_ptr == 4'd9) ? 4'd0 : r_ptr + 4'd1;
        end
    end

    // Free-running cursor blink phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink <= '0;
            r_phase <= 1'b0;
        end else begin
            r_blink <= w_blink_end ? '0 : r_blink + 1'b1;
            if (w_blink_end) r_phase <= ~r_phase;
        end
    end

    // Once-per-frame snapshot; the first edge after reset also captures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap  <= '0;
            r_first <= 1'b1;
            r_tick  <= 1'b0;
        end else begin
            r_first <= 1'b0;
            r_tick  <= w_snap;
            if (w_snap) r_snap <= w_live;
        end
    end

    // Registered digit enable and segment drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= '1;
            r_out <= SEG_BLANK;
        end else begin
            r_an  <= w_blank ? '1 : ~(N_CELLS'(1) << r_ptr);
            r_out <= w_blank ? SEG_BLANK : w_seg;
        end
    end

    assign bus.seg_an     = r_an;
    assign bus.seg_out    = r_out;
    assign bus.frame_tick = r_tick;
endmodule

// File: tb/tb_board_display_scan.sv
// tb_board_display_scan: directed checks of scan order, blanking, blink, dp and reset
module tb_board_display_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   ec = 0;
    int   tick_ec = 0;
    bit   got;
    logic [9:0] an_a [10];
    logic [9:0] an_b [10];
    logic [7:0] so_a [10];
    logic [7:0] so_b [10];
    localparam logic [7:0] DIG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    board_display_scan_if bus();

    board_display_scan #(.SCAN_DIV(4), .BLINK_DIV(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edges since reset release, used to predict the blink phase
    always @(posedge clk or posedge rst) begin
        if (rst) ec <= 0;
        else ec <= ec + 1;
    end

    task automatic grab_frame(input string name);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = bus.frame_tick;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s frame_tick: got 0 within 100 cycles, want 1", name);
        end
        tick_ec = ec;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 10; d++) begin
            an_a[d] = bus.seg_an;
            so_a[d] = bus.seg_out;
            @(negedge clk);
            an_b[d] = bus.seg_an;
            so_b[d] = bus.seg_out;
            if (d < 9) repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bus.status = 40'h9876543210; bus.num = 3'd5; bus.cursor_idx = 4'd15;
        bus.sel_valid = 1'b0; bus.sel_idx = 4'd0;
        repeat (3) @(negedge clk);
        tests++; if (bus.seg_an !== 10'h3FF) begin fails++; $display("FAIL reset seg_an: got %h want 3ff", bus.seg_an); end
        tests++; if (bus.seg_out !== 8'hFF) begin fails++; $display("FAIL reset seg_out: got %h want ff", bus.seg_out); end
        tests++; if (bus.frame_tick !== 1'b0) begin fails++; $display("FAIL reset frame_tick: got %b want 0", bus.frame_tick); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.frame_tick !== 1'b1) begin fails++; $display("FAIL release frame_tick: got %b want 1", bus.frame_tick); end
    endtask

    task automatic test_scan();
        logic [9:0] ea;
        grab_frame("scan");
        for (int d = 0; d < 10; d++) begin
            ea = ~(10'd1 << d);
            tests++; if (an_a[d] !== ea || an_b[d] !== ea) begin fails++; $display("FAIL scan an d%0d: got %h/%h want %h", d, an_a[d], an_b[d], ea); end
            tests++; if (so_a[d] !== DIG[d] || so_b[d] !== DIG[d]) begin fails++; $display("FAIL scan seg d%0d: got %h/%h want %h", d, so_a[d], so_b[d], DIG[d]); end
        end
    endtask

    task automatic test_num2();
        logic [9:0] ea;
        logic [7:0] es;
        bus.num = 3'd2;
        grab_frame("num2");
        for (int d = 0; d < 10; d++) begin
            ea = (d % 5 < 2) ? ~(10'd1 << d) : 10'h3FF;
            es = (d % 5 < 2) ? DIG[d] : 8'hFF;
            tests++; if (an_a[d] !== ea || so_a[d] !== es) begin fails++; $display("FAIL num2 d%0d: got %h %h want %h %h", d, an_a[d], so_a[d], ea, es); end
        end
    endtask

    task automatic test_dp();
        bus.num = 3'd5; bus.sel_valid = 1'b1; bus.sel_idx = 4'd6;
        grab_frame("dp");
        tests++; if (an_a[6] !== 10'h3BF || so_a[6] !== 8'h02) begin fails++; $display("FAIL dp d6: got %h %h want 3bf 02", an_a[6], so_a[6]); end
        tests++; if (so_a[5] !== 8'h92) begin fails++; $display("FAIL dp d5: got %h want 92", so_a[5]); end
        @(negedge clk);
        tests++; if (bus.frame_tick !== 1'b1) begin fails++; $display("FAIL dp tick: got %b want 1", bus.frame_tick); end
        repeat (8) @(negedge clk);
        bus.sel_valid = 1'b0;
        repeat (18) @(negedge clk);
        tests++; if (bus.seg_an !== 10'h3BF || bus.seg_out !== 8'h02) begin fails++; $display("FAIL dp held: got %h %h want 3bf 02", bus.seg_an, bus.seg_out); end
        grab_frame("dp_clear");
        tests++; if (an_a[6] !== 10'h3BF || so_a[6] !== 8'h82) begin fails++; $display("FAIL dp clear d6: got %h %h want 3bf 82", an_a[6], so_a[6]); end
    endtask

    task automatic test_blink();
        bit seen0 = 0;
        bit seen1 = 0;
        bit ph;
        bus.cursor_idx = 4'd3;
        for (int f = 0; f < 6; f++) begin
            grab_frame("blink");
            ph = (((tick_ec - 1) / 64) % 2) == 1;
            if (ph) seen1 = 1; else seen0 = 1;
            tests++;
            if (an_a[3] !== (ph ? 10'h3FF : 10'h3F7) || so_a[3] !== (ph ? 8'hFF : 8'hB0)) begin
                fails++; $display("FAIL blink f%0d d3: got %h %h phase %0d", f, an_a[3], so_a[3], ph);
            end
            tests++; if (an_a[2] !== 10'h3FB || so_a[2] !== 8'hA4) begin fails++; $display("FAIL blink f%0d d2: got %h %h want 3fb a4", f, an_a[2], so_a[2]); end
        end
        tests++; if (!(seen0 && seen1)) begin fails++; $display("FAIL blink phases: got seen0=%0d seen1=%0d want both 1", seen0, seen1); end
        bus.cursor_idx = 4'd15;
    endtask

    task automatic test_dash();
        logic [9:0] ea;
        logic [7:0] es;
        bus.status = 40'h98765B3210; bus.sel_valid = 1'b1; bus.sel_idx = 4'd12; bus.num = 3'd7;
        grab_frame("dash");
        tests++; if (an_a[4] !== 10'h3EF || so_a[4] !== 8'hBF) begin fails++; $display("FAIL dash d4: got %h %h want 3ef bf", an_a[4], so_a[4]); end
        for (int d = 0; d < 10; d++) begin
            tests++; if (so_a[d][7] !== 1'b1) begin fails++; $display("FAIL sel12 dp d%0d: got %h want dp off", d, so_a[d]); end
        end
        bus.num = 3'd0;
        grab_frame("num0");
        for (int d = 0; d < 10; d++) begin
            ea = (d % 5 == 0) ? ~(10'd1 << d) : 10'h3FF;
            es = (d % 5 == 0) ? DIG[d] : 8'hFF;
            tests++; if (an_a[d] !== ea || so_a[d] !== es) begin fails++; $display("FAIL num0 d%0d: got %h %h want %h %h", d, an_a[d], so_a[d], ea, es); end
        end
    endtask

    task automatic test_reset_mid();
        bus.status = 40'h9876543210; bus.num = 3'd5; bus.sel_valid = 1'b0;
        grab_frame("pre_rst");
        @(negedge clk);
        repeat (30) @(negedge clk);
        tests++; if (bus.seg_an !== 10'h37F || bus.seg_out !== 8'hF8) begin fails++; $display("FAIL digit7: got %h %h want 37f f8", bus.seg_an, bus.seg_out); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.seg_an !== 10'h3FF || bus.seg_out !== 8'hFF || bus.frame_tick !== 1'b0) begin
            fails++; $display("FAIL async rst: got %h %h %b want 3ff ff 0", bus.seg_an, bus.seg_out, bus.frame_tick);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.frame_tick !== 1'b1) begin fails++; $display("FAIL rerelease tick: got %b want 1", bus.frame_tick); end
        tests++; if (bus.seg_an !== 10'h3FE || bus.seg_out !== 8'hC0) begin fails++; $display("FAIL rerelease d0: got %h %h want 3fe c0", bus.seg_an, bus.seg_out); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_num2();
        test_dp();
        test_blink();
        test_dash();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
